// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the control sequencer: opcodes, ALU codes,
// sequencer states and instruction classes.
package cpu_defs_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_NOP = 5'b00000;
  localparam logic [4:0] ALU_ADD = 5'b00011;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    IC_ALU, IC_LD, IC_LDI, IC_ST, IC_NOP, IC_HALT, IC_ILLEGAL
  } iclass_t;

  // True on the final state of the instruction class, where stop is honoured.
  function automatic logic is_last(input state_t s, input iclass_t c);
    case (c)
      IC_ALU, IC_LDI:            is_last = (s == S_T5);
      IC_LD, IC_ST:              is_last = (s == S_T7);
      IC_NOP, IC_HALT, IC_ILLEGAL: is_last = (s == S_T3);
      default:                   is_last = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Instruction/start/stop inputs and all control outputs of the sequencer.
interface control_sequencer_if;
  logic [31:0] ir;
  logic        start;
  logic        stop;
  logic        PCout, Zlowout, MDRout, BAout, Cout;
  logic        MARIn, ZIn, PCIn, MDRIn, IRIn, YIn;
  logic        Gra, Grb, Grc, Rin, Rout;
  logic        IncPC, read, write;
  logic [4:0]  alu_op;
  logic        run;
  logic        illegal;

  modport master (
    output ir, start, stop,
    input  PCout, Zlowout, MDRout, BAout, Cout,
    input  MARIn, ZIn, PCIn, MDRIn, IRIn, YIn,
    input  Gra, Grb, Grc, Rin, Rout,
    input  IncPC, read, write, alu_op, run, illegal
  );

  modport slave (
    input  ir, start, stop,
    output PCout, Zlowout, MDRout, BAout, Cout,
    output MARIn, ZIn, PCIn, MDRIn, IRIn, YIn,
    output Gra, Grb, Grc, Rin, Rout,
    output IncPC, read, write, alu_op, run, illegal
  );
endinterface

// File: rtl/opcode_decoder.sv
// Maps the 5-bit opcode onto an instruction class; unlisted opcodes are illegal.
module opcode_decoder
  import cpu_defs_pkg::*;
(
  input  logic [4:0] opcode,
  output iclass_t    iclass
);

  // Opcode to class lookup
  always_comb begin
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: iclass = IC_ALU;
      OP_LD:                         iclass = IC_LD;
      OP_LDI:                        iclass = IC_LDI;
      OP_ST:                         iclass = IC_ST;
      OP_NOP:                        iclass = IC_NOP;
      OP_HALT:                       iclass = IC_HALT;
      default:                       iclass = IC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-state control unit: steps T0..T7 per instruction class and
// decodes every control output from the current state and ir.
module control_sequencer
  import cpu_defs_pkg::*;
(
  input  logic                clk,
  input  logic                clear_n,
  control_sequencer_if.slave  bus
);

  state_t     state;
  iclass_t    iclass;
  state_t     end_state;
  logic [4:0] opcode;
  logic       unused_ir_bits;

  assign opcode         = bus.ir[31:27];
  assign unused_ir_bits = ^bus.ir[26:0];
  assign end_state      = (iclass == IC_HALT || bus.stop) ? S_HALT : S_T0;

  opcode_decoder u_dec (
    .opcode (opcode),
    .iclass (iclass)
  );

  // State register; clear_n abandons any instruction in flight
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state <= S_RST;
    end else begin
      case (state)
        S_RST:  state <= S_T0;
        S_T0:   state <= S_T1;
        S_T1:   state <= S_T2;
        S_T2:   state <= S_T3;
        S_T3:   state <= is_last(S_T3, iclass) ? end_state : S_T4;
        S_T4:   state <= S_T5;
        S_T5:   state <= is_last(S_T5, iclass) ? end_state : S_T6;
        S_T6:   state <= S_T7;
        S_T7:   state <= end_state;
        S_HALT: state <= bus.start ? S_T0 : S_HALT;
        default: state <= S_RST;
      endcase
    end
  end

  // Control decode from state and instruction class
  always_comb begin
    bus.PCout = 1'b0; bus.Zlowout = 1'b0; bus.MDRout = 1'b0;
    bus.BAout = 1'b0; bus.Cout = 1'b0;
    bus.MARIn = 1'b0; bus.ZIn = 1'b0; bus.PCIn = 1'b0;
    bus.MDRIn = 1'b0; bus.IRIn = 1'b0; bus.YIn = 1'b0;
    bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0;
    bus.Rin = 1'b0; bus.Rout = 1'b0;
    bus.IncPC = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    bus.alu_op = ALU_NOP;
    bus.illegal = 1'b0;
    bus.run = (state != S_RST) && (state != S_HALT);
    case (state)
      S_T0: begin
        bus.PCout = 1'b1; bus.MARIn = 1'b1; bus.IncPC = 1'b1; bus.ZIn = 1'b1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1; bus.PCIn = 1'b1; bus.read = 1'b1; bus.MDRIn = 1'b1;
      end
      S_T2: begin
        bus.MDRout = 1'b1; bus.IRIn = 1'b1;
      end
      S_T3: begin
        if (iclass == IC_ALU) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.YIn = 1'b1;
        end else if (iclass == IC_LD || iclass == IC_LDI || iclass == IC_ST) begin
          bus.Grb = 1'b1; bus.BAout = 1'b1; bus.YIn = 1'b1;
        end else begin
          bus.illegal = (iclass == IC_ILLEGAL);
        end
      end
      S_T4: begin
        if (iclass == IC_ALU) begin
          bus.Grc = 1'b1; bus.Rout = 1'b1; bus.ZIn = 1'b1; bus.alu_op = opcode;
        end else if (iclass == IC_LD || iclass == IC_LDI || iclass == IC_ST) begin
          bus.Cout = 1'b1; bus.ZIn = 1'b1; bus.alu_op = ALU_ADD;
        end else begin
          bus.alu_op = ALU_NOP;
        end
      end
      S_T5: begin
        bus.Zlowout = 1'b1;
        if (iclass == IC_ALU || iclass == IC_LDI) begin
          bus.Gra = 1'b1; bus.Rin = 1'b1;
        end else begin
          bus.MARIn = 1'b1;
        end
      end
      S_T6: begin
        // ld pulls memory into MDR; st loads MDR from the source register
        bus.MDRIn = 1'b1;
        if (iclass == IC_ST) begin
          bus.Gra = 1'b1; bus.Rout = 1'b1;
        end else begin
          bus.read = 1'b1;
        end
      end
      S_T7: begin
        if (iclass == IC_ST) begin
          bus.write = 1'b1;
        end else begin
          bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end
      end
      default: begin
        bus.run = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks each instruction class through
// its T-states and checks every control output against hand-built vectors.
module tb_control_sequencer;

  logic clk;
  logic clear_n;
  int   checks = 0;
  int   errors = 0;

  control_sequencer_if bus ();

  control_sequencer dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [20:0] PCOUT   = 21'd1 << 20;
  localparam logic [20:0] ZLOWOUT = 21'd1 << 19;
  localparam logic [20:0] MDROUT  = 21'd1 << 18;
  localparam logic [20:0] BAOUT   = 21'd1 << 17;
  localparam logic [20:0] COUT    = 21'd1 << 16;
  localparam logic [20:0] MARIN   = 21'd1 << 15;
  localparam logic [20:0] ZIN     = 21'd1 << 14;
  localparam logic [20:0] PCIN    = 21'd1 << 13;
  localparam logic [20:0] MDRIN   = 21'd1 << 12;
  localparam logic [20:0] IRIN    = 21'd1 << 11;
  localparam logic [20:0] YIN     = 21'd1 << 10;
  localparam logic [20:0] GRA     = 21'd1 << 9;
  localparam logic [20:0] GRB     = 21'd1 << 8;
  localparam logic [20:0] GRC     = 21'd1 << 7;
  localparam logic [20:0] RIN     = 21'd1 << 6;
  localparam logic [20:0] ROUT    = 21'd1 << 5;
  localparam logic [20:0] INCPC   = 21'd1 << 4;
  localparam logic [20:0] READ    = 21'd1 << 3;
  localparam logic [20:0] WRITE   = 21'd1 << 2;
  localparam logic [20:0] RUN     = 21'd1 << 1;
  localparam logic [20:0] ILLEGAL = 21'd1 << 0;

  localparam logic [20:0] E_T0 = PCOUT | MARIN | INCPC | ZIN | RUN;
  localparam logic [20:0] E_T1 = ZLOWOUT | PCIN | READ | MDRIN | RUN;
  localparam logic [20:0] E_T2 = MDROUT | IRIN | RUN;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [20:0] mask, input logic [4:0] alu);
    logic [25:0] obs;
    logic [25:0] exp;
    obs = {bus.PCout, bus.Zlowout, bus.MDRout, bus.BAout, bus.Cout,
           bus.MARIn, bus.ZIn, bus.PCIn, bus.MDRIn, bus.IRIn, bus.YIn,
           bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout,
           bus.IncPC, bus.read, bus.write, bus.run, bus.illegal, bus.alu_op};
    exp = {mask, alu};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input string name);
    tick(); check({name, "_T1"}, E_T1, 5'b00000);
    tick(); check({name, "_T2"}, E_T2, 5'b00000);
  endtask

  initial begin
    clear_n   = 1'b0;
    bus.ir    = 32'h0000_0000;
    bus.start = 1'b1;
    bus.stop  = 1'b0;
    tick(); tick();
    check("rst", 21'd0, 5'b00000);
    bus.start = 1'b0;

    // and R5,R2,R4
    clear_n = 1'b1;
    bus.ir  = 32'h4A92_0000;
    tick(); check("and_T0", E_T0, 5'b00000);
    fetch("and");
    tick(); check("and_T3", GRB | ROUT | YIN | RUN, 5'b00000);
    tick(); check("and_T4", GRC | ROUT | ZIN | RUN, 5'b01001);
    tick(); check("and_T5", ZLOWOUT | GRA | RIN | RUN, 5'b00000);
    tick(); check("and_next_T0", E_T0, 5'b00000);

    // ld R1,0x55(R0)
    bus.ir = 32'h0080_0055;
    fetch("ld");
    tick(); check("ld_T3", GRB | BAOUT | YIN | RUN, 5'b00000);
    tick(); check("ld_T4", COUT | ZIN | RUN, 5'b00011);
    tick(); check("ld_T5", ZLOWOUT | MARIN | RUN, 5'b00000);
    tick(); check("ld_T6", READ | MDRIN | RUN, 5'b00000);
    tick(); check("ld_T7", MDROUT | GRA | RIN | RUN, 5'b00000);
    tick(); check("ld_next_T0", E_T0, 5'b00000);

    // st 0x1F(R2),R3
    bus.ir = 32'h1190_001F;
    fetch("st");
    tick(); check("st_T3", GRB | BAOUT | YIN | RUN, 5'b00000);
    tick(); check("st_T4", COUT | ZIN | RUN, 5'b00011);
    tick(); check("st_T5", ZLOWOUT | MARIN | RUN, 5'b00000);
    tick(); check("st_T6", GRA | ROUT | MDRIN | RUN, 5'b00000);
    tick(); check("st_T7", WRITE | RUN, 5'b00000);
    tick(); check("st_next_T0", E_T0, 5'b00000);

    // add with stop raised mid-instruction and dropped before T5
    bus.ir = 32'h1800_0000;
    fetch("add1");
    bus.stop = 1'b1;
    tick(); check("add1_T3", GRB | ROUT | YIN | RUN, 5'b00000);
    tick(); check("add1_T4", GRC | ROUT | ZIN | RUN, 5'b00011);
    bus.stop = 1'b0;
    tick(); check("add1_T5", ZLOWOUT | GRA | RIN | RUN, 5'b00000);
    tick(); check("add1_stop_ignored_T0", E_T0, 5'b00000);

    // add with stop on the last state halts
    fetch("add2");
    tick(); tick();
    tick(); check("add2_T5", ZLOWOUT | GRA | RIN | RUN, 5'b00000);
    bus.stop = 1'b1;
    tick(); check("add2_halt", 21'd0, 5'b00000);
    tick(); check("add2_halt_hold", 21'd0, 5'b00000);
    bus.start = 1'b1;
    tick(); check("start_stop_T0", E_T0, 5'b00000);
    bus.start = 1'b0;
    bus.stop  = 1'b0;

    // halt instruction, then restart
    bus.ir = 32'hD800_0000;
    fetch("halt");
    tick(); check("halt_T3", RUN, 5'b00000);
    tick(); check("halt_state", 21'd0, 5'b00000);
    tick(); check("halt_hold", 21'd0, 5'b00000);
    bus.start = 1'b1;
    tick(); check("restart_T0", E_T0, 5'b00000);
    bus.start = 1'b0;

    // sub interrupted by clear_n in T4
    bus.ir = 32'h2000_0000;
    fetch("sub");
    tick(); check("sub_T3", GRB | ROUT | YIN | RUN, 5'b00000);
    tick(); check("sub_T4", GRC | ROUT | ZIN | RUN, 5'b00100);
    clear_n = 1'b0;
    tick(); check("sub_abort_rst", 21'd0, 5'b00000);
    clear_n = 1'b1;
    bus.ir  = 32'hF800_0000;
    tick(); check("rst_release_T0", E_T0, 5'b00000);

    // undefined opcode 11111
    fetch("ill");
    tick(); check("ill_T3", RUN | ILLEGAL, 5'b00000);
    tick(); check("ill_next_T0", E_T0, 5'b00000);

    // nop
    bus.ir = 32'hD000_0000;
    fetch("nop");
    tick(); check("nop_T3", RUN, 5'b00000);
    tick(); check("nop_next_T0", E_T0, 5'b00000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
